// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the pipeline hazard controller: mul/div tracker
// state encodings, parameter defaults and the register-match helper.
// The optional mul/div busy tracker is enabled with HAZARD_MULDIV_EN.
package hazard_unit_pkg;

    // Mul/div tracker state encodings
    localparam logic MD_IDLE = 1'b0;
    localparam logic MD_BUSY = 1'b1;

    // Parameter defaults
    localparam int MULDIV_LAT_DEFAULT = 4;
    localparam int CNT_W_DEFAULT      = 32;

    // True when a producer destination feeds either ID source register.
    // Register 0 is hard-wired to zero and never creates a dependency.
    function automatic logic reg_match(
        input logic [4:0] rd,
        input logic [4:0] rs,
        input logic [4:0] rt
    );
        return (rd != 5'd0) && ((rd == rs) || (rd == rt));
    endfunction

endpackage

// File: rtl/muldiv_tracker.sv
// HI/LO unit busy tracker: a two-state FSM plus a down-counter that keeps
// md_busy high for exactly MULDIV_LAT cycles after a mult/div is accepted
// from EX. md_busy is the FSM state bit itself, so it doubles as the
// state debug output. Only instantiated when HAZARD_MULDIV_EN is defined.
module muldiv_tracker
    import hazard_unit_pkg::*;
#(
    parameter int MULDIV_LAT = MULDIV_LAT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic accept,
    output logic md_busy
);

    localparam int CW = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(MULDIV_LAT - 1);

    logic          state_q;
    logic          state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next-state: load on accept, count down while busy (a memory freeze
    // does not pause the HI/LO unit), return to idle when the count is spent.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == MD_IDLE) begin
            if (accept) begin
                state_d = MD_BUSY;
                cnt_d   = RELOAD;
            end
        end else begin
            if (accept) begin
                // A second op while busy restarts the latency window.
                cnt_d = RELOAD;
            end else if (cnt_q == '0) begin
                state_d = MD_IDLE;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    // State and counter registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign md_busy = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller for the 5-stage MIPS core. Produces the
// stage stall enables and the ID/EX bubble from load-use hazards, ID-stage
// branch operand hazards, cache-miss freezes and (with HAZARD_MULDIV_EN
// defined) HI/LO unit busy hazards. Also counts fetch-stall cycles in a
// saturating counter.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int MULDIV_LAT = MULDIV_LAT_DEFAULT,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             RegWrite_IE,
    input  logic             MemtoReg_IE,
    input  logic [4:0]       RegisterRd_IE,
    input  logic             RegWrite_EM,
    input  logic             MemtoReg_EM,
    input  logic [4:0]       RegisterRd_EM,
    input  logic [4:0]       RegisterRs_FD,
    input  logic [4:0]       RegisterRt_FD,
    input  logic             Branch_FD,
    input  logic             MulDiv_FD,
    input  logic             MulDiv_IE,
    input  logic             MfHiLo_FD,
    input  logic             ICache_stall,
    input  logic             DCache_stall,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             StallW,
    output logic             FlushE,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    logic match_e;
    logic match_m;
    logic lw_stall;
    logic br_stall;
    logic md_stall;
    logic mem_stall;
    logic hz;

    // Dependency detection. EX ALU results are bypassed into ID for branch
    // compares, so only a load sitting in MEM blocks a branch.
    always_comb begin
        match_e   = reg_match(RegisterRd_IE, RegisterRs_FD, RegisterRt_FD);
        match_m   = reg_match(RegisterRd_EM, RegisterRs_FD, RegisterRt_FD);
        lw_stall  = RegWrite_IE & MemtoReg_IE & match_e;
        br_stall  = Branch_FD & RegWrite_EM & MemtoReg_EM & match_m;
        mem_stall = ICache_stall | DCache_stall;
    end

`ifdef HAZARD_MULDIV_EN
    logic md_accept;

    // A mult/div leaving EX is only taken by the HI/LO unit if the pipe moves.
    assign md_accept = MulDiv_IE & ~mem_stall;
    assign md_stall  = (MfHiLo_FD | MulDiv_FD) & (md_busy | MulDiv_IE);

    muldiv_tracker #(
        .MULDIV_LAT (MULDIV_LAT)
    ) u_muldiv_tracker (
        .clk     (clk),
        .rst_n   (rst_n),
        .accept  (md_accept),
        .md_busy (md_busy)
    );
`else
    // HI/LO tracking disabled: its inputs are intentionally ignored.
    logic unused_md_inputs;

    assign unused_md_inputs = MulDiv_FD ^ MulDiv_IE ^ MfHiLo_FD;
    assign md_stall         = 1'b0;
    assign md_busy          = 1'b0;
`endif

    assign hz = lw_stall | br_stall | md_stall;

    // Stall/flush priority: a cache miss freezes the whole pipe without a
    // bubble; otherwise a hazard holds IF/ID and injects a bubble into EX.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        StallW = 1'b0;
        FlushE = 1'b0;
        if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            StallW = 1'b1;
        end else if (hz) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    // Saturating count of cycles in which fetch was held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (StallF && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit. Expected output vectors are queued
// when stimulus is driven and compared at the following negative edge.
// A second instance with a 4-bit counter exercises counter saturation.
module tb_hazard_unit;

    // Output vector layout: {StallF,StallD,StallE,StallM,StallW,FlushE,md_busy}
    localparam logic [6:0] E_NONE = 7'b0000000;
    localparam logic [6:0] E_HZ   = 7'b1100010;
    localparam logic [6:0] E_MEM  = 7'b1111100;
    localparam logic [6:0] E_BUSY = 7'b0000001;

`ifdef HAZARD_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       RegWrite_IE, MemtoReg_IE, RegWrite_EM, MemtoReg_EM;
    logic [4:0] RegisterRd_IE, RegisterRd_EM, RegisterRs_FD, RegisterRt_FD;
    logic       Branch_FD, MulDiv_FD, MulDiv_IE, MfHiLo_FD;
    logic       ICache_stall, DCache_stall;

    logic        StallF, StallD, StallE, StallM, StallW, FlushE, md_busy;
    logic [31:0] stall_cycles;
    logic        s_StallF, s_StallD, s_StallE, s_StallM, s_StallW, s_FlushE, s_md_busy;
    logic [3:0]  s_stall_cycles;

    logic [6:0] obs;
    assign obs = {StallF, StallD, StallE, StallM, StallW, FlushE, md_busy};

    hazard_unit #(.MULDIV_LAT(4), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .RegWrite_IE(RegWrite_IE), .MemtoReg_IE(MemtoReg_IE), .RegisterRd_IE(RegisterRd_IE),
        .RegWrite_EM(RegWrite_EM), .MemtoReg_EM(MemtoReg_EM), .RegisterRd_EM(RegisterRd_EM),
        .RegisterRs_FD(RegisterRs_FD), .RegisterRt_FD(RegisterRt_FD), .Branch_FD(Branch_FD),
        .MulDiv_FD(MulDiv_FD), .MulDiv_IE(MulDiv_IE), .MfHiLo_FD(MfHiLo_FD),
        .ICache_stall(ICache_stall), .DCache_stall(DCache_stall),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
        .FlushE(FlushE), .md_busy(md_busy), .stall_cycles(stall_cycles)
    );

    hazard_unit #(.MULDIV_LAT(4), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .RegWrite_IE(RegWrite_IE), .MemtoReg_IE(MemtoReg_IE), .RegisterRd_IE(RegisterRd_IE),
        .RegWrite_EM(RegWrite_EM), .MemtoReg_EM(MemtoReg_EM), .RegisterRd_EM(RegisterRd_EM),
        .RegisterRs_FD(RegisterRs_FD), .RegisterRt_FD(RegisterRt_FD), .Branch_FD(Branch_FD),
        .MulDiv_FD(MulDiv_FD), .MulDiv_IE(MulDiv_IE), .MfHiLo_FD(MfHiLo_FD),
        .ICache_stall(ICache_stall), .DCache_stall(DCache_stall),
        .StallF(s_StallF), .StallD(s_StallD), .StallE(s_StallE), .StallM(s_StallM), .StallW(s_StallW),
        .FlushE(s_FlushE), .md_busy(s_md_busy), .stall_cycles(s_stall_cycles)
    );

    // ---------------- scoreboard state ----------------
    logic [6:0]  exp_q[$];
    logic [6:0]  exp_v;
    logic [31:0] exp_cnt;
    int          n_cmp  = 0;
    int          n_fail = 0;

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        RegWrite_IE = 1'b0; MemtoReg_IE = 1'b0; RegisterRd_IE = 5'd0;
        RegWrite_EM = 1'b0; MemtoReg_EM = 1'b0; RegisterRd_EM = 5'd0;
        RegisterRs_FD = 5'd0; RegisterRt_FD = 5'd0; Branch_FD = 1'b0;
        MulDiv_FD = 1'b0; MulDiv_IE = 1'b0; MfHiLo_FD = 1'b0;
        ICache_stall = 1'b0; DCache_stall = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        drive_idle();
        rst_n = 1'b0;
        exp_cnt = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference for the random test (no mul/div activity).
    function automatic logic [6:0] ref_out();
        logic me, mm, hz;
        me = (RegisterRd_IE != 5'd0) && (RegisterRd_IE == RegisterRs_FD || RegisterRd_IE == RegisterRt_FD);
        mm = (RegisterRd_EM != 5'd0) && (RegisterRd_EM == RegisterRs_FD || RegisterRd_EM == RegisterRt_FD);
        hz = (RegWrite_IE && MemtoReg_IE && me) || (Branch_FD && RegWrite_EM && MemtoReg_EM && mm);
        if (ICache_stall || DCache_stall) return E_MEM;
        if (hz) return E_HZ;
        return E_NONE;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        exp_cnt = 32'd0;
        exp_q.push_back(E_NONE);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL reset_outputs: got %b expected %b", obs, exp_v); end
        n_cmp++;
        if (stall_cycles !== exp_cnt) begin n_fail++; $display("FAIL reset_count: got %0d expected %0d", stall_cycles, exp_cnt); end
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            drive_idle();
            RegWrite_IE = 1'b1; MemtoReg_IE = 1'b1;
            case (i)
                0: begin RegisterRd_IE = 5'd8; RegisterRs_FD = 5'd8; exp_q.push_back(E_HZ); end
                1: begin RegisterRd_IE = 5'd8; RegisterRs_FD = 5'd3; RegisterRt_FD = 5'd8; exp_q.push_back(E_HZ); end
                2: begin RegisterRd_IE = 5'd0; exp_q.push_back(E_NONE); end
                3: begin RegWrite_IE = 1'b0; RegisterRd_IE = 5'd8; RegisterRs_FD = 5'd8; exp_q.push_back(E_NONE); end
                4: begin MemtoReg_IE = 1'b0; RegisterRd_IE = 5'd8; RegisterRs_FD = 5'd8; exp_q.push_back(E_NONE); end
                default: begin RegisterRd_IE = 5'd8; RegisterRs_FD = 5'd9; RegisterRt_FD = 5'd10; exp_q.push_back(E_NONE); end
            endcase
            @(negedge clk);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL load_use[%0d]: got %b expected %b", i, obs, exp_v); end
            n_cmp++;
            if (stall_cycles !== exp_cnt) begin n_fail++; $display("FAIL load_use_count[%0d]: got %0d expected %0d", i, stall_cycles, exp_cnt); end
            if (exp_v[6]) exp_cnt++;
        end
    endtask

    task automatic test_branch();
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            drive_idle();
            Branch_FD = 1'b1; RegWrite_EM = 1'b1; MemtoReg_EM = 1'b1; RegisterRd_EM = 5'd9;
            case (i)
                0: begin RegisterRt_FD = 5'd9; exp_q.push_back(E_HZ); end
                1: begin RegisterRt_FD = 5'd9; MemtoReg_EM = 1'b0; exp_q.push_back(E_NONE); end
                2: begin RegisterRt_FD = 5'd9; Branch_FD = 1'b0; exp_q.push_back(E_NONE); end
                3: begin
                    RegWrite_EM = 1'b0; RegWrite_IE = 1'b1; RegisterRd_IE = 5'd9;
                    RegisterRs_FD = 5'd9; exp_q.push_back(E_NONE);
                end
                4: begin RegisterRd_EM = 5'd0; exp_q.push_back(E_NONE); end
                default: begin RegisterRs_FD = 5'd9; RegisterRt_FD = 5'd4; exp_q.push_back(E_HZ); end
            endcase
            @(negedge clk);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL branch[%0d]: got %b expected %b", i, obs, exp_v); end
            n_cmp++;
            if (stall_cycles !== exp_cnt) begin n_fail++; $display("FAIL branch_count[%0d]: got %0d expected %0d", i, stall_cycles, exp_cnt); end
            if (exp_v[6]) exp_cnt++;
        end
    endtask

    task automatic test_cache();
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            drive_idle();
            case (i)
                0, 1, 2: begin
                    DCache_stall = 1'b1; RegWrite_IE = 1'b1; MemtoReg_IE = 1'b1;
                    RegisterRd_IE = 5'd8; RegisterRs_FD = 5'd8; exp_q.push_back(E_MEM);
                end
                3: begin ICache_stall = 1'b1; exp_q.push_back(E_MEM); end
                4: begin
                    ICache_stall = 1'b1; Branch_FD = 1'b1; RegWrite_EM = 1'b1; MemtoReg_EM = 1'b1;
                    RegisterRd_EM = 5'd9; RegisterRt_FD = 5'd9; exp_q.push_back(E_MEM);
                end
                default: exp_q.push_back(E_NONE);
            endcase
            @(negedge clk);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL cache[%0d]: got %b expected %b", i, obs, exp_v); end
            n_cmp++;
            if (stall_cycles !== exp_cnt) begin n_fail++; $display("FAIL cache_count[%0d]: got %0d expected %0d", i, stall_cycles, exp_cnt); end
            if (exp_v[6]) exp_cnt++;
        end
    endtask

    task automatic test_muldiv();
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            drive_idle();
            case (i)
                0: begin MulDiv_IE = 1'b1; MfHiLo_FD = 1'b1; exp_q.push_back(MD_EN ? E_HZ : E_NONE); end
                1, 2, 3, 4: begin MfHiLo_FD = 1'b1; exp_q.push_back(MD_EN ? (E_HZ | E_BUSY) : E_NONE); end
                5, 6: begin MfHiLo_FD = 1'b1; exp_q.push_back(E_NONE); end
                7: begin MulDiv_IE = 1'b1; ICache_stall = 1'b1; exp_q.push_back(E_MEM); end
                8: exp_q.push_back(E_NONE);
                9: begin MulDiv_IE = 1'b1; MulDiv_FD = 1'b1; exp_q.push_back(MD_EN ? E_HZ : E_NONE); end
                10, 11, 12, 13: exp_q.push_back(MD_EN ? E_BUSY : E_NONE);
                default: exp_q.push_back(E_NONE);
            endcase
            @(negedge clk);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL muldiv[%0d]: got %b expected %b", i, obs, exp_v); end
            n_cmp++;
            if (stall_cycles !== exp_cnt) begin n_fail++; $display("FAIL muldiv_count[%0d]: got %0d expected %0d", i, stall_cycles, exp_cnt); end
            if (exp_v[6]) exp_cnt++;
        end
    endtask

    task automatic test_reset_mid_busy();
        // cycle 0: op accepted; cycle 1: busy
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            drive_idle();
            MulDiv_IE = (i == 0);
            exp_q.push_back((i == 1 && MD_EN) ? E_BUSY : E_NONE);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL mid_busy_pre[%0d]: got %b expected %b", i, obs, exp_v); end
        end
        // cycle 2: asynchronous reset while busy, mfhi waiting in ID
        @(posedge clk); #1;
        drive_idle();
        MfHiLo_FD = 1'b1;
        rst_n = 1'b0;
        exp_cnt = 32'd0;
        exp_q.push_back(E_NONE);
        #1;
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL mid_busy_reset: got %b expected %b", obs, exp_v); end
        n_cmp++;
        if (stall_cycles !== exp_cnt) begin n_fail++; $display("FAIL mid_busy_reset_count: got %0d expected %0d", stall_cycles, exp_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            exp_q.push_back(E_NONE);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL mid_busy_post[%0d]: got %b expected %b", i, obs, exp_v); end
        end
        drive_idle();
    endtask

    task automatic test_saturation();
        pulse_reset();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            DCache_stall = 1'b1;
            exp_q.push_back(E_MEM);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL sat_outputs[%0d]: got %b expected %b", i, obs, exp_v); end
            n_cmp++;
            if (s_stall_cycles !== ((i > 15) ? 4'd15 : 4'(i))) begin
                n_fail++; $display("FAIL sat_count[%0d]: got %0d expected %0d", i, s_stall_cycles, (i > 15) ? 15 : i);
            end
            exp_cnt++;
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            DCache_stall = (i == 1);
            @(negedge clk);
            n_cmp++;
            if (s_stall_cycles !== 4'd15) begin n_fail++; $display("FAIL sat_hold[%0d]: got %0d expected 15", i, s_stall_cycles); end
            n_cmp++;
            if (stall_cycles !== exp_cnt) begin n_fail++; $display("FAIL sat_wide_count[%0d]: got %0d expected %0d", i, stall_cycles, exp_cnt); end
            if (DCache_stall) exp_cnt++;
        end
        drive_idle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            drive_idle();
            RegWrite_IE   = 1'($urandom_range(0, 1));
            MemtoReg_IE   = 1'($urandom_range(0, 1));
            RegisterRd_IE = 5'($urandom_range(0, 3));
            RegWrite_EM   = 1'($urandom_range(0, 1));
            MemtoReg_EM   = 1'($urandom_range(0, 1));
            RegisterRd_EM = 5'($urandom_range(0, 3));
            RegisterRs_FD = 5'($urandom_range(0, 3));
            RegisterRt_FD = 5'($urandom_range(0, 3));
            Branch_FD     = 1'($urandom_range(0, 1));
            ICache_stall  = ($urandom_range(0, 7) == 0);
            DCache_stall  = ($urandom_range(0, 7) == 0);
            exp_q.push_back(ref_out());
            @(negedge clk);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL random[%0d]: got %b expected %b", i, obs, exp_v); end
            n_cmp++;
            if (stall_cycles !== exp_cnt) begin n_fail++; $display("FAIL random_count[%0d]: got %0d expected %0d", i, stall_cycles, exp_cnt); end
            if (exp_v[6]) exp_cnt++;
        end
        drive_idle();
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_cache();
        test_muldiv();
        test_reset_mid_busy();
        test_saturation();
        pulse_reset();
        test_back_to_back();
        n_cmp++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
